// File: rtl/ahb_lite_arbiter2_pkg.sv
// Shared AHB-Lite constants, FSM encodings and the captured-request record
// used by the two-master arbiter.
package ahb_lite_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ADDR = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    localparam int NUM_MST = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } ahb_req_t;

    // IDLE and BUSY never open a transfer; NONSEQ and SEQ both do.
    function automatic logic is_req(input logic sel, input logic [1:0] trans);
        return sel && (trans == HTRANS_NONSEQ || trans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_lite_arbiter2_if.sv
// One AHB-Lite link; the arbiter is a slave on each master link and a
// master on the shared slave link.
interface ahb_lite_arbiter2_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HSEL;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_arbiter2_port.sv
// Per-master front end: captures one request, stalls the master until the
// arbiter reports completion, then returns registered read data and response.
module ahb_lite_arb_port
    import ahb_lite_arb_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        hsel,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        done,
    input  logic [31:0] s_rdata,
    input  logic        s_resp,
    output logic        hready,
    output logic [31:0] hrdata,
    output logic        hresp,
    output ahb_req_t    pend,
    output logic        pend_valid
);

    logic capture;

    // While stalled the master's address-phase inputs are ignored.
    assign capture = hready && is_req(hsel, htrans);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hready     <= 1'b1;
            hrdata     <= '0;
            hresp      <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (done) begin
            hrdata     <= s_rdata;
            hresp      <= s_resp;
            hready     <= 1'b1;
            pend_valid <= 1'b0;
        end else if (capture) begin
            pend       <= '{addr: haddr, write: hwrite, size: hsize};
            pend_valid <= 1'b1;
            hready     <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: serialises captured requests onto one slave
// as SINGLE/NONSEQ transfers with no address/data overlap.
module ahb_lite_arbiter2
    import ahb_lite_arb_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahb_lite_arbiter2_if.slave  m0,
    ahb_lite_arbiter2_if.slave  m1,
    ahb_lite_arbiter2_if.master s
);

    logic [NUM_MST-1:0]       m_hsel, m_hwrite, m_hready, m_hresp;
    logic [NUM_MST-1:0]       pend_valid, done;
    logic [NUM_MST-1:0][1:0]  m_htrans;
    logic [NUM_MST-1:0][2:0]  m_hsize;
    logic [NUM_MST-1:0][31:0] m_haddr, m_hwdata, m_hrdata;
    ahb_req_t [NUM_MST-1:0]   pend;

    logic [1:0] state;
    logic       grant, last_grant, nxt_grant;
    logic       unused_hburst;

    assign m_hsel   = {m1.HSEL,   m0.HSEL};
    assign m_hwrite = {m1.HWRITE, m0.HWRITE};
    assign m_htrans = {m1.HTRANS, m0.HTRANS};
    assign m_hsize  = {m1.HSIZE,  m0.HSIZE};
    assign m_haddr  = {m1.HADDR,  m0.HADDR};
    assign m_hwdata = {m1.HWDATA, m0.HWDATA};
    assign unused_hburst = ^{m0.HBURST, m1.HBURST};

    for (genvar i = 0; i < NUM_MST; i++) begin : g_port
        ahb_lite_arb_port u_port (
            .HCLK       (HCLK),
            .HRESET     (HRESET),
            .hsel       (m_hsel[i]),
            .htrans     (m_htrans[i]),
            .haddr      (m_haddr[i]),
            .hwrite     (m_hwrite[i]),
            .hsize      (m_hsize[i]),
            .done       (done[i]),
            .s_rdata    (s.HRDATA),
            .s_resp     (s.HRESP),
            .hready     (m_hready[i]),
            .hrdata     (m_hrdata[i]),
            .hresp      (m_hresp[i]),
            .pend       (pend[i]),
            .pend_valid (pend_valid[i])
        );
    end

    assign m0.HREADY = m_hready[0];
    assign m1.HREADY = m_hready[1];
    assign m0.HRDATA = m_hrdata[0];
    assign m1.HRDATA = m_hrdata[1];
    assign m0.HRESP  = m_hresp[0];
    assign m1.HRESP  = m_hresp[1];

    // Grant decision from registered pend_valid only, so a request captured
    // at this edge cannot win at this same edge.
    always_comb begin
        nxt_grant = last_grant;
        if (pend_valid == 2'b11)
            nxt_grant = (PRIORITY_MODE != 0) ? 1'b0 : ~last_grant;
        else if (pend_valid[0])
            nxt_grant = 1'b0;
        else if (pend_valid[1])
            nxt_grant = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (|pend_valid) begin
                    grant      <= nxt_grant;
                    last_grant <= nxt_grant;
                    state      <= ST_ADDR;
                end
                ST_ADDR: if (s.HREADY) state <= ST_DATA;
                ST_DATA: if (s.HREADY) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign done = (state == ST_DATA && s.HREADY) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    // HSEL is the slave's only address qualifier, so it is confined to ADDR.
    assign s.HSEL   = (state == ST_ADDR);
    assign s.HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s.HBURST = HBURST_SINGLE;
    assign s.HADDR  = pend[grant].addr;
    assign s.HWRITE = pend[grant].write;
    assign s.HSIZE  = pend[grant].size;
    assign s.HWDATA = m_hwdata[grant];

endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Scoreboard bench: round-robin and fixed-priority arbiters run the same
// directed traffic against 1-wait-state slave models.
module tb_ahb_lite_arbiter2;
    import ahb_lite_arb_pkg::*;

    typedef struct {
        int          gap;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_resp;
        int          exp_low;
    } cmd_t;
    typedef struct { logic [31:0] rdata; logic resp; int low; } mexp_t;
    typedef struct { logic [31:0] addr; logic wr; } sexp_t;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_haddr [2][2];
    logic        m_hsel  [2][2];
    logic [1:0]  m_htrans[2][2];
    logic        m_hwrite[2][2];
    logic [31:0] m_hwdata[2][2];
    logic [31:0] m_hrdata[2][2];
    logic        m_hready[2][2];
    logic        m_hresp [2][2];
    logic        s_hsel  [2];
    logic [1:0]  s_htrans[2];
    logic [31:0] s_haddr [2];
    logic        s_hwrite[2];
    logic [2:0]  s_hburst[2];

    mexp_t mq[4][$];
    sexp_t sq[2][$];
    cmd_t  ctab[2][4];
    int    cn[2];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    for (genvar p = 0; p < 2; p++) begin : g_dut
        ahb_lite_arbiter2_if m0_if ();
        ahb_lite_arbiter2_if m1_if ();
        ahb_lite_arbiter2_if s_if ();
        logic [31:0] mem [64];
        logic [1:0]  ph;
        logic [31:0] sa;
        logic        sw;

        assign m0_if.HADDR  = m_haddr[p][0];
        assign m0_if.HBURST = 3'b001;
        assign m0_if.HSEL   = m_hsel[p][0];
        assign m0_if.HSIZE  = 3'b010;
        assign m0_if.HTRANS = m_htrans[p][0];
        assign m0_if.HWDATA = m_hwdata[p][0];
        assign m0_if.HWRITE = m_hwrite[p][0];
        assign m1_if.HADDR  = m_haddr[p][1];
        assign m1_if.HBURST = 3'b001;
        assign m1_if.HSEL   = m_hsel[p][1];
        assign m1_if.HSIZE  = 3'b010;
        assign m1_if.HTRANS = m_htrans[p][1];
        assign m1_if.HWDATA = m_hwdata[p][1];
        assign m1_if.HWRITE = m_hwrite[p][1];
        assign m_hrdata[p][0] = m0_if.HRDATA;
        assign m_hready[p][0] = m0_if.HREADY;
        assign m_hresp[p][0]  = m0_if.HRESP;
        assign m_hrdata[p][1] = m1_if.HRDATA;
        assign m_hready[p][1] = m1_if.HREADY;
        assign m_hresp[p][1]  = m1_if.HRESP;
        assign s_hsel[p]   = s_if.HSEL;
        assign s_htrans[p] = s_if.HTRANS;
        assign s_haddr[p]  = s_if.HADDR;
        assign s_hwrite[p] = s_if.HWRITE;
        assign s_hburst[p] = s_if.HBURST;

        ahb_lite_arbiter2 #(.PRIORITY_MODE(p)) u_dut (
            .HCLK   (HCLK),
            .HRESET (HRESET),
            .m0     (m0_if),
            .m1     (m1_if),
            .s      (s_if)
        );

        // Slave: one wait state in every data phase; word at index i starts as 0x1000_0000+i.
        assign s_if.HREADY = (ph != 2'd1);
        assign s_if.HRDATA = (ph == 2'd2 && !sw) ? mem[sa[7:2]] : 32'h0;
        assign s_if.HRESP  = (ph == 2'd2 && sa == 32'hF0);
        always @(posedge HCLK) begin
            if (HRESET) begin
                ph <= 2'd0;
                for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            end else if (ph == 2'd0 && s_if.HSEL && s_if.HTRANS[1]) begin
                ph <= 2'd1;
                sa <= s_if.HADDR;
                sw <= s_if.HWRITE;
            end else if (ph == 2'd1) begin
                ph <= 2'd2;
            end else if (ph == 2'd2) begin
                if (sw) mem[sa[7:2]] <= s_if.HWDATA;
                ph <= 2'd0;
            end
        end

        initial begin
            sexp_t se;
            forever begin
                @(negedge HCLK);
                if (!HRESET && s_hsel[p]) begin
                    if (sq[p].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL p%0d unexpected slave transfer: got addr %h, expected none", p, s_haddr[p]);
                    end else begin
                        se = sq[p].pop_front();
                        chk($sformatf("p%0d S_HADDR", p), s_haddr[p], se.addr);
                        chk($sformatf("p%0d S_HWRITE", p), 32'(s_hwrite[p]), 32'(se.wr));
                        chk($sformatf("p%0d S_HTRANS", p), 32'(s_htrans[p]), 32'(HTRANS_NONSEQ));
                        chk($sformatf("p%0d S_HBURST", p), 32'(s_hburst[p]), 32'(HBURST_SINGLE));
                    end
                end
            end
        end

        for (genvar m = 0; m < 2; m++) begin : g_mon
            initial begin
                mexp_t e;
                logic  prv;
                logic  prst;
                int    low;
                prv = 1'b1;
                prst = 1'b0;
                low = 0;
                forever begin
                    @(negedge HCLK);
                    if (HRESET || prst) begin
                        low = 0;
                    end else if (!m_hready[p][m]) begin
                        low++;
                    end else if (!prv) begin
                        if (mq[p*2+m].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL p%0d m%0d unexpected completion: got data %h, expected none", p, m, m_hrdata[p][m]);
                        end else begin
                            e = mq[p*2+m].pop_front();
                            chk($sformatf("p%0d M%0d_HRDATA", p, m), m_hrdata[p][m], e.rdata);
                            chk($sformatf("p%0d M%0d_HRESP", p, m), 32'(m_hresp[p][m]), 32'(e.resp));
                            if (e.low != 0)
                                chk($sformatf("p%0d M%0d stall cycles", p, m), 32'(low), 32'(e.low));
                        end
                        low = 0;
                    end
                    prv = m_hready[p][m];
                    prst = HRESET;
                end
            end
        end
    end

    function automatic cmd_t mk(input int gap, input logic [31:0] a, input logic wr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic rs, input int low);
        cmd_t c;
        c = '{gap: gap, addr: a, wr: wr, wdata: wd, exp_rdata: rd, exp_resp: rs, exp_low: low};
        return c;
    endfunction

    task automatic drive_addr(input int p, input int m, input logic sel, input logic [1:0] tr,
                              input logic [31:0] a, input logic w);
        m_hsel[p][m]   = sel;
        m_htrans[p][m] = tr;
        m_haddr[p][m]  = a;
        m_hwrite[p][m] = w;
    endtask

    task automatic issue(input int p, input int m, input cmd_t c);
        mexp_t e;
        drive_addr(p, m, 1'b1, HTRANS_NONSEQ, c.addr, c.wr);
        e = '{rdata: c.exp_rdata, resp: c.exp_resp, low: c.exp_low};
        mq[p*2+m].push_back(e);
    endtask

    // Returns just after the first edge at which this master's HREADY is high.
    task automatic wait_rdy(input int p, input int m, output bit ok);
        int k;
        k = 0;
        ok = 1'b1;
        @(negedge HCLK);
        while (m_hready[p][m] !== 1'b1) begin
            k++;
            if (k > 60) begin
                ok = 1'b0;
                tests++;
                fails++;
                $display("FAIL p%0d m%0d HREADY timeout: got 0 for %0d cycles, expected 1", p, m, k);
                return;
            end
            @(negedge HCLK);
        end
        @(posedge HCLK);
        #1;
    endtask

    task automatic master_seq(input int p, input int m);
        cmd_t c;
        bit   ok;
        for (int i = 0; i < cn[m]; i++) begin
            c = ctab[m][i];
            if (i == 0 || c.gap > 0) begin
                repeat (c.gap) begin @(posedge HCLK); #1; end
                issue(p, m, c);
                wait_rdy(p, m, ok);
                if (!ok) return;
            end
            m_hwdata[p][m] = c.wdata;
            if (i + 1 < cn[m] && ctab[m][i+1].gap == 0) issue(p, m, ctab[m][i+1]);
            else drive_addr(p, m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0);
            wait_rdy(p, m, ok);
            if (!ok) return;
        end
        drive_addr(p, m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0);
    endtask

    task automatic drain_check(input string n);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s p%0d slave queue left", n, p), 32'(sq[p].size()), 32'd0);
            for (int m = 0; m < 2; m++)
                chk($sformatf("%s p%0d m%0d completions left", n, p, m), 32'(mq[p*2+m].size()), 32'd0);
        end
    endtask

    task automatic run_phase(input string n);
        fork
            master_seq(0, 0);
            master_seq(0, 1);
            master_seq(1, 0);
            master_seq(1, 1);
        join
        repeat (4) @(posedge HCLK);
        #1;
        drain_check(n);
    endtask

    task automatic push_s(input int p, input logic [31:0] a, input logic w);
        sexp_t se;
        se = '{addr: a, wr: w};
        sq[p].push_back(se);
    endtask

    task automatic check_idle_outputs(input string n);
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s p%0d S_HSEL", n, p), 32'(s_hsel[p]), 32'd0);
            chk($sformatf("%s p%0d S_HTRANS", n, p), 32'(s_htrans[p]), 32'(HTRANS_IDLE));
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("%s p%0d M%0d_HREADY", n, p, m), 32'(m_hready[p][m]), 32'd1);
                chk($sformatf("%s p%0d M%0d_HRDATA", n, p, m), m_hrdata[p][m], 32'd0);
                chk($sformatf("%s p%0d M%0d_HRESP", n, p, m), 32'(m_hresp[p][m]), 32'd0);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int p = 0; p < 2; p++)
            for (int m = 0; m < 2; m++) begin
                drive_addr(p, m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0);
                m_hwdata[p][m] = 32'h0;
            end
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check_idle_outputs("reset");

        // Isolated reads from M0, the second hitting the error address.
        cn[0] = 2;
        cn[1] = 0;
        ctab[0][0] = mk(0, 32'h10, 1'b0, 32'h0, 32'h1000_0004, 1'b0, 4);
        ctab[0][1] = mk(2, 32'hF0, 1'b0, 32'h0, 32'h1000_003C, 1'b1, 4);
        for (int p = 0; p < 2; p++) begin push_s(p, 32'h10, 1'b0); push_s(p, 32'hF0, 1'b0); end
        run_phase("single");

        // M1 write then read-back pipelined into the completion cycle.
        cn[0] = 0;
        cn[1] = 2;
        ctab[1][0] = mk(0, 32'h04, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 4);
        ctab[1][1] = mk(0, 32'h04, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);
        for (int p = 0; p < 2; p++) begin push_s(p, 32'h04, 1'b1); push_s(p, 32'h04, 1'b0); end
        run_phase("wr_rd");

        // Both masters streaming 3 reads from the same start edge.
        cn[0] = 3;
        cn[1] = 3;
        ctab[0][0] = mk(0, 32'h20, 1'b0, 32'h0, 32'h1000_0008, 1'b0, 4);
        ctab[0][1] = mk(0, 32'h24, 1'b0, 32'h0, 32'h1000_0009, 1'b0, 0);
        ctab[0][2] = mk(0, 32'h28, 1'b0, 32'h0, 32'h1000_000A, 1'b0, 0);
        ctab[1][0] = mk(0, 32'h40, 1'b0, 32'h0, 32'h1000_0010, 1'b0, 8);
        ctab[1][1] = mk(0, 32'h44, 1'b0, 32'h0, 32'h1000_0011, 1'b0, 0);
        ctab[1][2] = mk(0, 32'h48, 1'b0, 32'h0, 32'h1000_0012, 1'b0, 0);
        for (int p = 0; p < 2; p++) begin
            push_s(p, 32'h20, 1'b0); push_s(p, 32'h40, 1'b0);
            push_s(p, 32'h24, 1'b0); push_s(p, 32'h44, 1'b0);
            push_s(p, 32'h28, 1'b0); push_s(p, 32'h48, 1'b0);
        end
        run_phase("stream");

        // M0 alone (last grant = M0), then a true tie: RR picks M1, priority picks M0.
        cn[0] = 2;
        cn[1] = 1;
        ctab[0][0] = mk(0, 32'h50, 1'b0, 32'h0, 32'h1000_0014, 1'b0, 4);
        ctab[0][1] = mk(3, 32'h54, 1'b0, 32'h0, 32'h1000_0015, 1'b0, 0);
        ctab[1][0] = mk(9, 32'h58, 1'b0, 32'h0, 32'h1000_0016, 1'b0, 0);
        push_s(0, 32'h50, 1'b0); push_s(0, 32'h58, 1'b0); push_s(0, 32'h54, 1'b0);
        push_s(1, 32'h50, 1'b0); push_s(1, 32'h54, 1'b0); push_s(1, 32'h58, 1'b0);
        run_phase("tie");

        // BUSY with HSEL, and NONSEQ without HSEL: neither is a request.
        for (int p = 0; p < 2; p++) begin
            drive_addr(p, 0, 1'b1, HTRANS_BUSY, 32'h80, 1'b0);
            drive_addr(p, 1, 1'b0, HTRANS_NONSEQ, 32'h84, 1'b1);
        end
        repeat (4) begin
            @(negedge HCLK);
            for (int p = 0; p < 2; p++)
                for (int m = 0; m < 2; m++)
                    chk($sformatf("nocap p%0d M%0d_HREADY", p, m), 32'(m_hready[p][m]), 32'd1);
        end
        @(posedge HCLK);
        #1;
        for (int p = 0; p < 2; p++) for (int m = 0; m < 2; m++)
            drive_addr(p, m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0);
        repeat (4) @(posedge HCLK);
        #1;
        drain_check("nocap");

        // Reset while the first of two pending transfers is in its data phase.
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check_idle_outputs("reset2");
        for (int p = 0; p < 2; p++) begin
            drive_addr(p, 0, 1'b1, HTRANS_NONSEQ, 32'h30, 1'b0);
            drive_addr(p, 1, 1'b1, HTRANS_NONSEQ, 32'h34, 1'b0);
            push_s(p, 32'h30, 1'b0);
        end
        @(posedge HCLK);
        #1;
        for (int p = 0; p < 2; p++) for (int m = 0; m < 2; m++)
            drive_addr(p, m, 1'b0, HTRANS_IDLE, 32'h0, 1'b0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check_idle_outputs("midreset");
        repeat (12) @(posedge HCLK);
        #1;
        drain_check("midreset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
